// File: rtl/iob_pcie_rx_chnl_pkg.sv
// Shared types and constants for the PCIe RX channel engine.
package iob_pcie_rx_chnl_pkg;

   localparam int unsigned IOB_PCIE_CHNL_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACK     = 3'd1,
      ST_DATA    = 3'd2,
      ST_WAITLOW = 3'd3,
      ST_DONE    = 3'd4
   } rx_state_e;

endpackage

// File: rtl/iob_pcie_rx_fifo.sv
// Synchronous FIFO buffering received channel words; the head output holds the
// last popped word while the FIFO is empty.
module iob_pcie_rx_fifo #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   level_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   level_q;
   logic [DATA_W-1:0] hold_q;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (level_q == (ADDR_W+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

   // Storage array carries no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         hold_q   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            hold_q   <= mem_q[rd_ptr_q];
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/iob_pcie_rx_chnl.sv
// Host-to-FPGA channel engine: request/ack handshake, word intake into a FIFO,
// and per-transaction status (len/off/last/count/done/short).
module iob_pcie_rx_chnl
   import iob_pcie_rx_chnl_pkg::*;
#(
   parameter int unsigned FIFO_ADDR_W = 4,
   parameter int unsigned DATA_W      = IOB_PCIE_CHNL_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CHNL_RX,
   output logic              CHNL_RX_CLK,
   output logic              CHNL_RX_ACK,
   input  logic              CHNL_RX_LAST,
   input  logic [31:0]       CHNL_RX_LEN,
   input  logic [30:0]       CHNL_RX_OFF,
   input  logic [DATA_W-1:0] CHNL_RX_DATA,
   input  logic              CHNL_RX_DATA_VALID,
   output logic              CHNL_RX_DATA_REN,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       rx_len,
   output logic [30:0]       rx_off,
   output logic              rx_last,
   output logic [31:0]       rx_count,
   output logic              busy,
   output logic              done,
   output logic              short
);

   rx_state_e         state_q, state_d;
   logic [31:0]       len_q, len_d;
   logic [30:0]       off_q, off_d;
   logic              last_q, last_d;
   logic [31:0]       count_q, count_d;
   logic              short_q, short_d;
   logic              ack_q, done_q, busy_q;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_ADDR_W:0] fifo_level;

   assign CHNL_RX_CLK      = CLK;
   // REN is decoded from registered state only; no path from VALID.
   assign CHNL_RX_DATA_REN = (state_q == ST_DATA) && (count_q < len_q) && !fifo_full;
   assign fifo_pop         = m_ready && !fifo_empty;
   assign m_valid          = (fifo_level != '0);

   assign CHNL_RX_ACK = ack_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign rx_len      = len_q;
   assign rx_off      = off_q;
   assign rx_last     = last_q;
   assign rx_count    = count_q;
   assign short       = short_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      off_d     = off_q;
      last_d    = last_q;
      count_d   = count_q;
      short_d   = short_q;
      fifo_push = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (CHNL_RX) begin
               state_d = ST_ACK;
               len_d   = CHNL_RX_LEN;
               off_d   = CHNL_RX_OFF;
               last_d  = CHNL_RX_LAST;
               count_d = '0;
               short_d = 1'b0;
            end
         end
         ST_ACK: begin
            state_d = (len_q != '0) ? ST_DATA : ST_WAITLOW;
         end
         ST_DATA: begin
            if (CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID) begin
               fifo_push = 1'b1;
               count_d   = count_q + 32'd1;
            end
            // Completion wins over a simultaneous request drop.
            if (count_d == len_q) begin
               state_d = ST_WAITLOW;
            end else if (!CHNL_RX) begin
               state_d = ST_DONE;
               short_d = 1'b1;
            end
         end
         ST_WAITLOW: begin
            if (!CHNL_RX) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         off_q   <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
         short_q <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         off_q   <= off_d;
         last_q  <= last_d;
         count_q <= count_d;
         short_q <= short_d;
         ack_q   <= (state_d == ST_ACK);
         done_q  <= (state_d == ST_DONE);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   iob_pcie_rx_fifo #(
      .ADDR_W (FIFO_ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push_i  (fifo_push),
      .data_i  (CHNL_RX_DATA),
      .pop_i   (fifo_pop),
      .data_o  (m_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

endmodule
